// File: rtl/rv_isa_pkg.sv
// Shared RV32IM-subset ISA definitions for the instruction encoder.
// Holds the major opcode constants, the bit positions of the packed
// codif field {sel11, sel10, funct3[2:0], opcode[6:0]} and the word
// emitted for an unencodable request.
package rv_isa_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_IRQ    = 7'b0011000;

  // codif field positions
  localparam int unsigned CODIF_OP_LSB = 0;
  localparam int unsigned CODIF_OP_MSB = 6;
  localparam int unsigned CODIF_F3_LSB = 7;
  localparam int unsigned CODIF_F3_MSB = 9;
  localparam int unsigned CODIF_SEL10  = 10;
  localparam int unsigned CODIF_SEL11  = 11;

  // Sentinel word for an illegal request
  localparam logic [31:0] ILL_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/inst_field_pack.sv
// Combinational field packer: builds a 32-bit RV32IM-subset instruction
// word from the decoded field set. Inverse of the core's decoder.
// Ports:
//   codif   in  12  {sel11, sel10, funct3, opcode}
//   rd/rs1/rs2 in 5 register fields
//   imm     in  32  decoder-format immediate (shift amount in imm[4:0])
//   inst    out 32  encoded word, ILL_WORD when unencodable
//   illegal out 1   request could not be encoded
module inst_field_pack
  import rv_isa_pkg::*;
#(
  parameter logic [31:0] ILL_WORD = ILL_WORD_DEF
) (
  input  logic [11:0] codif,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        illegal
);

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_s10;
  logic        w_s11;
  logic [31:0] w_word;
  logic        w_bad;

  assign w_op  = codif[CODIF_OP_MSB:CODIF_OP_LSB];
  assign w_f3  = codif[CODIF_F3_MSB:CODIF_F3_LSB];
  assign w_s10 = codif[CODIF_SEL10];
  assign w_s11 = codif[CODIF_SEL11];

  always_comb begin
    w_word = '0;
    w_bad  = 1'b0;
    case (w_op)
      OPC_LUI, OPC_AUIPC: begin
        w_word = {imm[31:12], rd, w_op};
        w_bad  = (codif[11:7] != 5'd0);
      end
      OPC_JAL: begin
        w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, w_op};
        w_bad  = (codif[11:7] != 5'd0) || imm[0];
      end
      OPC_JALR: begin
        w_word = {imm[11:0], rs1, 3'b000, rd, w_op};
        w_bad  = (w_f3 != 3'b000) || w_s11 || w_s10;
      end
      OPC_BRANCH: begin
        w_word = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11], w_op};
        w_bad  = (w_f3 == 3'b010) || (w_f3 == 3'b011) || imm[0];
      end
      OPC_LOAD: begin
        w_word = {imm[11:0], rs1, w_f3, rd, w_op};
        w_bad  = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_word = {imm[11:5], rs2, rs1, w_f3, imm[4:0], w_op};
        w_bad  = w_f3[2] || (w_f3 == 3'b011);
      end
      OPC_OPIMM: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // Shift: sel10 selects arithmetic right shift, so only valid with SRxI
          w_word = {1'b0, w_s10, 5'b0, imm[4:0], rs1, w_f3, rd, w_op};
          w_bad  = w_s11 || (w_s10 && (w_f3 != 3'b101));
        end else begin
          w_word = {imm[11:0], rs1, w_f3, rd, w_op};
          w_bad  = w_s11 || w_s10;
        end
      end
      OPC_OP: begin
        // sel11 -> funct7[5] (SUB/SRA), sel10 -> funct7[0] (M extension)
        w_word = {1'b0, w_s11, 4'b0, w_s10, rs2, rs1, w_f3, rd, w_op};
        w_bad  = (w_s11 && w_s10) || (w_s10 && w_f3[2]);
      end
      OPC_SYSTEM: begin
        w_word = {imm[11:0], rs1, w_f3, rd, w_op};
        w_bad  = (w_f3 == 3'b100) || w_s11 || w_s10;
      end
      OPC_IRQ: begin
        w_word = {imm[11:0], rs1, w_f3, rd, w_op};
        w_bad  = (w_f3 == 3'b000);
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
  end

  assign inst    = w_bad ? ILL_WORD : w_word;
  assign illegal = w_bad;

endmodule

// File: rtl/inst_encoder.sv
// Registered instruction encoder stage: one-entry pipeline register with
// valid/ready on both sides around inst_field_pack, plus saturating counters
// of legal and illegal words delivered downstream.
// Ports:
//   clock, resetEnc        clock and synchronous active-high reset
//   in_valid/in_ready      request handshake
//   codif, rd, rs1, rs2, imm  decoded field set
//   out_valid/out_ready    result handshake
//   inst, illegal          encoded word and its illegal qualifier
//   cnt_enc, cnt_ill       delivered legal / illegal word counters
module inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] ILL_WORD = ILL_WORD_DEF
) (
  input  logic             clock,
  input  logic             resetEnc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      codif,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             illegal,
  output logic [CNT_W-1:0] cnt_enc,
  output logic [CNT_W-1:0] cnt_ill
);

  logic [31:0]      w_inst;
  logic             w_ill;
  logic             w_accept;
  logic             w_xfer;
  logic             r_valid;
  logic [31:0]      r_inst;
  logic             r_ill;
  logic [CNT_W-1:0] r_cnt_enc;
  logic [CNT_W-1:0] r_cnt_ill;

  inst_field_pack #(
    .ILL_WORD(ILL_WORD)
  ) u_pack (
    .codif  (codif),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (imm),
    .inst   (w_inst),
    .illegal(w_ill)
  );

  // Reset gates in_ready so nothing is accepted on the reset edge
  assign in_ready = !resetEnc && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_valid && out_ready;

  always_ff @(posedge clock) begin
    if (resetEnc) begin
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_ill     <= 1'b0;
      r_cnt_enc <= '0;
      r_cnt_ill <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_inst  <= w_inst;
        r_ill   <= w_ill;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_xfer) begin
        if (!r_ill) begin
          if (r_cnt_enc != {CNT_W{1'b1}}) r_cnt_enc <= r_cnt_enc + 1'b1;
        end else begin
          if (r_cnt_ill != {CNT_W{1'b1}}) r_cnt_ill <= r_cnt_ill + 1'b1;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign inst      = r_inst;
  assign illegal   = r_ill;
  assign cnt_enc   = r_cnt_enc;
  assign cnt_ill   = r_cnt_ill;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (main instance with 16-bit
// counters, second instance with 2-bit counters for saturation).
module tb_inst_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] codif;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        illegal;
  logic [15:0] cnt_enc;
  logic [15:0] cnt_ill;

  logic        s_in_valid;
  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_inst;
  logic        s_illegal;
  logic [1:0]  s_cnt_enc;
  logic [1:0]  s_cnt_ill;

  int n_chk = 0;
  int n_err = 0;

  inst_encoder #(
    .CNT_W   (16),
    .ILL_WORD(32'hFFFF_FFFF)
  ) dut (
    .clock    (clk),
    .resetEnc (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .codif    (codif),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .inst     (inst),
    .illegal  (illegal),
    .cnt_enc  (cnt_enc),
    .cnt_ill  (cnt_ill)
  );

  inst_encoder #(
    .CNT_W   (2),
    .ILL_WORD(32'hFFFF_FFFF)
  ) dut_sat (
    .clock    (clk),
    .resetEnc (rst),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .codif    (codif),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .inst     (s_inst),
    .illegal  (s_illegal),
    .cnt_enc  (s_cnt_enc),
    .cnt_ill  (s_cnt_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [11:0] c, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im);
    codif    = c;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = im;
    in_valid = 1'b1;
  endtask

  // Present one request, clock it in, check the registered result
  task automatic send(input string tag, input logic [11:0] c, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                      input logic [31:0] exp_inst, input logic exp_ill);
    set_req(c, d, s1, s2, im);
    tick();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_inst"}, inst, exp_inst);
    chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    codif       = 12'h000;
    rd          = 5'd0;
    rs1         = 5'd0;
    rs2         = 5'd0;
    imm         = 32'd0;

    // Reset
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_cnt_enc", {16'd0, cnt_enc}, 32'd0);
    chk("rst_cnt_ill", {16'd0, cnt_ill}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream with out_ready=1
    send("addi", 12'h013, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    chk("addi_cnt", {16'd0, cnt_enc}, 32'd0);
    send("srli", 12'h293, 5'd3, 5'd4, 5'd0, 32'd5, 32'h0052_5193, 1'b0);
    chk("srli_cnt", {16'd0, cnt_enc}, 32'd1);
    send("srai", 12'h693, 5'd3, 5'd4, 5'd0, 32'd5, 32'h4052_5193, 1'b0);
    chk("srai_cnt", {16'd0, cnt_enc}, 32'd2);
    send("sub", 12'h833, 5'd5, 5'd6, 5'd7, 32'd0, 32'h4073_02B3, 1'b0);
    send("mul", 12'h433, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0231_00B3, 1'b0);
    send("jal", 12'h06F, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    send("beq", 12'h063, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    send("lui", 12'h037, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, 32'h1234_5537, 1'b0);
    send("sw", 12'h123, 5'd0, 5'd2, 5'd3, 32'h0000_07FF, 32'h7E31_2FA3, 1'b0);
    send("jalr_f3", 12'h0E7, 5'd1, 5'd2, 5'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    chk("jalr_cnt_enc", {16'd0, cnt_enc}, 32'd9);
    chk("jalr_cnt_ill", {16'd0, cnt_ill}, 32'd0);
    send("codif_fff", 12'hFFF, 5'd1, 5'd2, 5'd3, 32'd0, 32'hFFFF_FFFF, 1'b1);
    chk("fff_cnt_ill", {16'd0, cnt_ill}, 32'd1);
    send("slli_sel10", 12'h493, 5'd3, 5'd4, 5'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_cnt_enc", {16'd0, cnt_enc}, 32'd9);
    chk("drain_cnt_ill", {16'd0, cnt_ill}, 32'd3);

    // Backpressure: W1 stalls for 5 cycles while W2 waits
    out_ready = 1'b0;
    send("bp_w1", 12'h013, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    set_req(12'h013, 5'd2, 5'd0, 5'd0, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_hold_inst", inst, 32'h0010_0093);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    chk("bp_cnt_hold", {16'd0, cnt_enc}, 32'd9);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_w2_inst", inst, 32'h0020_0113);
    chk("bp_w2_cnt", {16'd0, cnt_enc}, 32'd10);
    send("bp_w3", 12'h013, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
    chk("bp_w3_cnt", {16'd0, cnt_enc}, 32'd11);
    send("bp_w4", 12'h013, 5'd4, 5'd0, 5'd0, 32'd4, 32'h0040_0213, 1'b0);
    chk("bp_w4_cnt", {16'd0, cnt_enc}, 32'd12);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_drain_cnt", {16'd0, cnt_enc}, 32'd13);

    // Reset while a word is held and stalled
    out_ready = 1'b0;
    send("rs_w", 12'h013, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    in_valid  = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rs_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_inst", inst, 32'd0);
    chk("rs_cnt_enc", {16'd0, cnt_enc}, 32'd0);
    chk("rs_cnt_ill", {16'd0, cnt_ill}, 32'd0);
    rst = 1'b0;

    // Saturation on the 2-bit counter instance: 5 legal transfers
    set_req(12'h013, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
    in_valid   = 1'b0;
    s_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_valid", {31'd0, s_out_valid}, 32'd1);
    end
    chk("sat_cnt_mid", {30'd0, s_cnt_enc}, 32'd3);
    chk("sat_inst", s_inst, 32'hFFF1_0093);
    s_in_valid = 1'b0;
    tick();
    chk("sat_cnt_enc", {30'd0, s_cnt_enc}, 32'd3);
    chk("sat_cnt_ill", {30'd0, s_cnt_ill}, 32'd0);
    chk("sat_illegal", {31'd0, s_illegal}, 32'd0);
    chk("sat_in_ready", {31'd0, s_in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
